// File: rtl/dmac_engine_if.sv
// dmac_engine_if: AXI4-Lite-style read/write channel bundle between the DMA engine and memory.
interface dmac_engine_if;
   logic [31:0] araddr_o;
   logic        arvalid_o;
   logic        arready_i;
   logic [31:0] rdata_i;
   logic [1:0]  rresp_i;
   logic        rvalid_i;
   logic        rready_o;
   logic [31:0] awaddr_o;
   logic        awvalid_o;
   logic        awready_i;
   logic [31:0] wdata_o;
   logic [3:0]  wstrb_o;
   logic        wvalid_o;
   logic        wready_i;
   logic [1:0]  bresp_i;
   logic        bvalid_i;
   logic        bready_o;
   modport master (
      output araddr_o, arvalid_o, rready_o, awaddr_o, awvalid_o, wdata_o, wstrb_o, wvalid_o, bready_o,
      input  arready_i, rdata_i, rresp_i, rvalid_i, awready_i, wready_i, bresp_i, bvalid_i
   );
   modport slave (
      input  araddr_o, arvalid_o, rready_o, awaddr_o, awvalid_o, wdata_o, wstrb_o, wvalid_o, bready_o,
      output arready_i, rdata_i, rresp_i, rvalid_i, awready_i, wready_i, bresp_i, bvalid_i
   );
endinterface

// File: rtl/dmac_engine.sv
// dmac_engine: single-beat word-by-word memory copy engine over AXI read and write channels.
module dmac_engine (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [31:0]        src_addr_i,
   input  logic [31:0]        dst_addr_i,
   input  logic [15:0]        byte_len_i,
   input  logic               start_i,
   output logic               done_o,
   output logic               error_o,
   dmac_engine_if.master      axi
);
   typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR, WR_RESP} state_e;
   state_e      state_q, state_d;
   logic [31:0] src_q, src_d, dst_q, dst_d, buf_q, buf_d;
   logic [13:0] cnt_q, cnt_d;
   logic        err_q, err_d, aw_done_q, aw_done_d, w_done_q, w_done_d;
   logic        awv, wv, aw_ok, w_ok;
   logic        unused;
   assign unused = ^{byte_len_i[1:0], axi.rresp_i[0], axi.bresp_i[0]};
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         src_q     <= '0;
         dst_q     <= '0;
         buf_q     <= '0;
         cnt_q     <= '0;
         err_q     <= 1'b0;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         src_q     <= src_d;
         dst_q     <= dst_d;
         buf_q     <= buf_d;
         cnt_q     <= cnt_d;
         err_q     <= err_d;
         aw_done_q <= aw_done_d;
         w_done_q  <= w_done_d;
      end
   end
   // each write valid falls on its own handshake; WR exits once both have been seen
   assign awv   = (state_q == WR) && !aw_done_q;
   assign wv    = (state_q == WR) && !w_done_q;
   assign aw_ok = aw_done_q || (awv && axi.awready_i);
   assign w_ok  = w_done_q || (wv && axi.wready_i);
   always_comb begin
      state_d   = state_q;
      src_d     = src_q;
      dst_d     = dst_q;
      buf_d     = buf_q;
      cnt_d     = cnt_q;
      err_d     = err_q;
      aw_done_d = 1'b0;
      w_done_d  = 1'b0;
      case (state_q)
         IDLE: if (start_i) begin
            src_d   = src_addr_i;
            dst_d   = dst_addr_i;
            cnt_d   = byte_len_i[15:2];
            err_d   = 1'b0;
            state_d = (byte_len_i[15:2] != 14'd0) ? RD_ADDR : IDLE;
         end
         RD_ADDR: state_d = axi.arready_i ? RD_DATA : RD_ADDR;
         RD_DATA: if (axi.rvalid_i) begin
            buf_d   = axi.rdata_i;
            err_d   = axi.rresp_i[1] ? 1'b1 : err_q;
            state_d = axi.rresp_i[1] ? IDLE : WR;
         end
         WR: begin
            aw_done_d = aw_ok && !w_ok;
            w_done_d  = w_ok && !aw_ok;
            state_d   = (aw_ok && w_ok) ? WR_RESP : WR;
         end
         WR_RESP: if (axi.bvalid_i) begin
            if (axi.bresp_i[1]) begin
               err_d   = 1'b1;
               state_d = IDLE;
            end else begin
               src_d   = src_q + 32'd4;
               dst_d   = dst_q + 32'd4;
               cnt_d   = cnt_q - 14'd1;
               state_d = (cnt_q == 14'd1) ? IDLE : RD_ADDR;
            end
         end
         default: state_d = IDLE;
      endcase
   end
   assign done_o        = (state_q == IDLE);
   assign error_o       = err_q;
   assign axi.araddr_o  = src_q;
   assign axi.arvalid_o = (state_q == RD_ADDR);
   assign axi.rready_o  = (state_q == RD_DATA);
   assign axi.awaddr_o  = dst_q;
   assign axi.awvalid_o = awv;
   assign axi.wdata_o   = buf_q;
   assign axi.wstrb_o   = 4'hF;
   assign axi.wvalid_o  = wv;
   assign axi.bready_o  = (state_q == WR_RESP);
endmodule

// File: tb/tb_dmac_engine.sv
// tb_dmac_engine: transaction-level model and directed scenarios for the DMA copy engine.
module tb_dmac_engine;
   logic        clk = 1'b0, rst_n = 1'b1;
   logic [31:0] src_addr_i = '0, dst_addr_i = '0;
   logic [15:0] byte_len_i = '0;
   logic        start_i = 1'b0, done_o, error_o;
   dmac_engine_if axi();
   dmac_engine dut (.clk(clk), .rst_n(rst_n), .src_addr_i(src_addr_i), .dst_addr_i(dst_addr_i),
                    .byte_len_i(byte_len_i), .start_i(start_i), .done_o(done_o), .error_o(error_o), .axi(axi));
   always #5 clk = ~clk;
   int checks = 0, errors = 0;
   int mode = 0, err_rd = -1, rd_idx = 0, rem_m = 0, cyc = 0;
   bit busy_m = 0, err_m = 0;
   logic [31:0] exp_ar[$], exp_aw[$], exp_w[$], ar_log[$], aw_log[$], w_log[$];
   logic [31:0] last_ar = '0, p_ara = '0, p_awa = '0, p_wd = '0;
   bit p_arv = 0, p_arhs = 0, p_awv = 0, p_awhs = 0, p_wv = 0, p_whs = 0;
   function automatic logic [31:0] mem(input logic [31:0] a);
      return a ^ 32'hDEAD_0000;
   endfunction
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask
   task automatic fail(input string name);
      checks++;
      errors++;
      $display("FAIL %s actual=event required=none", name);
   endtask
   function automatic void clear_model();
      exp_ar.delete();
      exp_aw.delete();
      exp_w.delete();
   endfunction
   // memory slave: ready/valid pattern chosen by mode, read data derived from the accepted address
   always @(posedge clk) begin
      logic r;
      #2;
      r = 1'($urandom_range(0, 1));
      axi.arready_i = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      axi.rvalid_i  = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      axi.bvalid_i  = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      axi.awready_i = (mode == 0) ? 1'b1 : (mode == 1) ? r : 1'b0;
      axi.wready_i  = (mode == 0) ? 1'b1 : (mode == 1) ? ~r : 1'b0;
      axi.rdata_i   = mem(last_ar);
      axi.rresp_i   = (rd_idx == err_rd) ? 2'b10 : 2'b00;
      axi.bresp_i   = 2'b00;
   end
   // per-cycle compare against the transaction model
   always @(negedge clk) begin
      bit idle, ar_hs, r_hs, aw_hs, w_hs, b_hs;
      int n;
      if (!rst_n) begin
         chk("rst_done", 32'(done_o), 32'd1);
         chk("rst_valids", 32'({axi.arvalid_o, axi.rready_o, axi.awvalid_o, axi.wvalid_o, axi.bready_o}), 32'd0);
         busy_m = 0;
         err_m = 0;
         clear_model();
         {p_arv, p_arhs, p_awv, p_awhs, p_wv, p_whs} = '0;
      end else begin
         idle = !busy_m;
         chk("done", 32'(done_o), 32'(!busy_m));
         chk("error", 32'(error_o), 32'(err_m));
         chk("wstrb", 32'(axi.wstrb_o), 32'hF);
         if (p_arv && !p_arhs) begin
            chk("ar_hold", 32'(axi.arvalid_o), 32'd1);
            chk("araddr_hold", axi.araddr_o, p_ara);
         end
         if (p_awv && !p_awhs) begin
            chk("aw_hold", 32'(axi.awvalid_o), 32'd1);
            chk("awaddr_hold", axi.awaddr_o, p_awa);
         end
         if (p_wv && !p_whs) begin
            chk("w_hold", 32'(axi.wvalid_o), 32'd1);
            chk("wdata_hold", axi.wdata_o, p_wd);
         end
         ar_hs = axi.arvalid_o && axi.arready_i;
         r_hs  = axi.rready_o && axi.rvalid_i;
         aw_hs = axi.awvalid_o && axi.awready_i;
         w_hs  = axi.wvalid_o && axi.wready_i;
         b_hs  = axi.bready_o && axi.bvalid_i;
         if (ar_hs) begin
            ar_log.push_back(axi.araddr_o);
            last_ar = axi.araddr_o;
            if (exp_ar.size() == 0) fail("ar_unexpected");
            else chk("araddr", axi.araddr_o, exp_ar.pop_front());
         end
         if (aw_hs) begin
            aw_log.push_back(axi.awaddr_o);
            if (exp_aw.size() == 0) fail("aw_unexpected");
            else chk("awaddr", axi.awaddr_o, exp_aw.pop_front());
         end
         if (w_hs) begin
            w_log.push_back(axi.wdata_o);
            if (exp_w.size() == 0) fail("w_unexpected");
            else chk("wdata", axi.wdata_o, exp_w.pop_front());
         end
         if (r_hs) begin
            rd_idx++;
            if (axi.rresp_i[1]) begin
               err_m = 1;
               busy_m = 0;
               clear_model();
            end
         end
         if (b_hs) begin
            rem_m--;
            if (rem_m == 0) busy_m = 0;
         end
         if (start_i && idle) begin
            err_m = 0;
            n = int'(byte_len_i) / 4;
            if (n != 0) begin
               busy_m = 1;
               rem_m = n;
               rd_idx = 0;
               for (int i = 0; i < n; i++) begin
                  exp_ar.push_back(src_addr_i + 32'(4 * i));
                  exp_aw.push_back(dst_addr_i + 32'(4 * i));
                  exp_w.push_back(mem(src_addr_i + 32'(4 * i)));
               end
            end
         end
         p_arv = axi.arvalid_o; p_arhs = ar_hs; p_ara = axi.araddr_o;
         p_awv = axi.awvalid_o; p_awhs = aw_hs; p_awa = axi.awaddr_o;
         p_wv  = axi.wvalid_o;  p_whs  = w_hs;  p_wd  = axi.wdata_o;
      end
   end
   task automatic run(input logic [31:0] s, input logic [31:0] d, input logic [15:0] len, input bit pulse, output int c);
      ar_log.delete();
      aw_log.delete();
      w_log.delete();
      @(posedge clk);
      #2;
      src_addr_i = s;
      dst_addr_i = d;
      byte_len_i = len;
      start_i = 1'b1;
      @(posedge clk);
      #2;
      start_i = 1'b0;
      c = 0;
      while (!done_o && c < 3000) begin
         @(posedge clk);
         #2;
         c++;
         if (pulse && c == 5) begin
            src_addr_i = 32'h0000_BAD0;
            start_i = 1'b1;
         end else if (pulse && c == 6) begin
            src_addr_i = s;
            start_i = 1'b0;
         end
      end
      if (!done_o) fail("done_timeout");
   endtask
   initial begin
      int k;
      {axi.arready_i, axi.rvalid_i, axi.awready_i, axi.wready_i, axi.bvalid_i} = '0;
      axi.rdata_i = '0;
      axi.rresp_i = '0;
      axi.bresp_i = '0;
      #1 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;
      chk("reset_araddr", axi.araddr_o, 32'h0);
      chk("reset_awaddr", axi.awaddr_o, 32'h0);
      chk("reset_wdata", axi.wdata_o, 32'h0);
      chk("reset_done_err", 32'({done_o, error_o}), 32'd2);
      mode = 0;
      run(32'h1000, 32'h2000, 16'd16, 0, cyc);
      chk("t1_cycles", cyc, 16);
      chk("t1_error", 32'(error_o), 0);
      chk("t1_nar", ar_log.size(), 4);
      chk("t1_ar3", ar_log[3], 32'h100C);
      chk("t1_aw0", aw_log[0], 32'h2000);
      chk("t1_aw3", aw_log[3], 32'h200C);
      chk("t1_w0", w_log[0], 32'hDEAD_1000);
      chk("t1_w3", w_log[3], 32'hDEAD_100C);
      chk("t1_pending", exp_ar.size() + exp_aw.size() + exp_w.size(), 0);
      run(32'h1000, 32'h2000, 16'd3, 0, cyc);
      repeat (5) @(posedge clk);
      #2;
      chk("t2_len3_cycles", cyc, 0);
      chk("t2_len3_activity", ar_log.size() + aw_log.size(), 0);
      run(32'h1000, 32'h2000, 16'd0, 0, cyc);
      repeat (5) @(posedge clk);
      #2;
      chk("t2_len0_activity", ar_log.size() + aw_log.size(), 0);
      chk("t2_done", 32'(done_o), 1);
      mode = 1;
      run(32'h3000, 32'h4000, 16'd20, 1, cyc);
      chk("t3_nw", w_log.size(), 5);
      chk("t3_ar0", ar_log[0], 32'h3000);
      chk("t3_w4", w_log[4], 32'hDEAD_3010);
      chk("t3_aw4", aw_log[4], 32'h4010);
      chk("t3_pending", exp_ar.size() + exp_aw.size() + exp_w.size(), 0);
      mode = 0;
      err_rd = 1;
      run(32'h5000, 32'h6000, 16'd12, 0, cyc);
      chk("t4_cycles", cyc, 6);
      chk("t4_error", 32'(error_o), 1);
      chk("t4_nar", ar_log.size(), 2);
      chk("t4_naw", aw_log.size(), 1);
      chk("t4_w0", w_log[0], 32'hDEAD_5000);
      err_rd = -1;
      run(32'h7000, 32'h8000, 16'd4, 0, cyc);
      chk("t4_clear_error", 32'(error_o), 0);
      chk("t4_next_cycles", cyc, 4);
      run(32'hFFFF_FFFC, 32'h0000_0100, 16'd8, 0, cyc);
      chk("t5_ar0", ar_log[0], 32'hFFFF_FFFC);
      chk("t5_ar1", ar_log[1], 32'h0);
      chk("t5_w1", w_log[1], 32'hDEAD_0000);
      chk("t5_aw1", aw_log[1], 32'h104);
      mode = 2;
      @(posedge clk);
      #2;
      src_addr_i = 32'hC000;
      dst_addr_i = 32'hD000;
      byte_len_i = 16'd8;
      start_i = 1'b1;
      @(posedge clk);
      #2;
      start_i = 1'b0;
      k = 0;
      while (!axi.awvalid_o && k < 50) begin
         @(posedge clk);
         #2;
         k++;
      end
      chk("t6_in_wr", 32'({axi.awvalid_o, axi.wvalid_o}), 32'd3);
      #1 rst_n = 1'b0;
      #1;
      chk("t6_async_valids", 32'({axi.awvalid_o, axi.wvalid_o, axi.arvalid_o}), 0);
      chk("t6_async_done", 32'(done_o), 1);
      @(posedge clk);
      #2 rst_n = 1'b1;
      mode = 0;
      run(32'h9000, 32'hA000, 16'd8, 0, cyc);
      chk("t6_cycles", cyc, 8);
      chk("t6_w1", w_log[1], 32'hDEAD_9004);
      chk("t6_aw0", aw_log[0], 32'hA000);
      repeat (3) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
